// File: rtl/ajuste_campo_pkg.sv
// rtl/ajuste_campo_pkg.sv - shared state encoding and RTC field maxima for the field edit controller
package ajuste_campo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } estado_t;

    localparam logic [6:0] MAX_SEG  = 7'd59;
    localparam logic [6:0] MAX_MIN  = 7'd59;
    localparam logic [6:0] MAX_HORA = 7'd23;
    localparam logic [6:0] MAX_DIA  = 7'd31;
    localparam logic [6:0] MAX_MES  = 7'd12;
    localparam logic [6:0] MAX_ANIO = 7'd99;

endpackage

// File: rtl/temporizador_repeticion.sv
// rtl/temporizador_repeticion.sv - hold/repeat interval counter with clear, enable and selectable terminal count
module temporizador_repeticion #(
    parameter int TERM_A = 4,
    parameter int TERM_B = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic sel,
    output logic done
);

    localparam int LARGEST = (TERM_A > TERM_B) ? TERM_A : TERM_B;
    localparam int CW      = $clog2(LARGEST);
    localparam logic [CW-1:0] LAST_A = CW'(TERM_A - 1);
    localparam logic [CW-1:0] LAST_B = CW'(TERM_B - 1);

    logic [CW-1:0] cnt;

    // done is only seen for one cycle because the controller clears on it
    assign done = enable && (cnt == (sel ? LAST_B : LAST_A));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ajuste_campo.sv
// rtl/ajuste_campo.sv - set-time edit controller for one RTC field with single step and auto-repeat
module ajuste_campo
    import ajuste_campo_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [6:0] max,
    input  logic       load,
    input  logic [6:0] value_in,
    output logic [6:0] value,
    output logic       write_strobe,
    output logic       busy
);

    estado_t    state, state_next;
    logic       dir_up, dir_up_next;
    logic       step, step_up;
    logic       timer_clear, timer_enable, timer_done;
    logic       any_btn, both_btn, latched_btn, other_btn;
    logic [6:0] stepped;

    assign any_btn     = btn_up | btn_down;
    assign both_btn    = btn_up & btn_down;
    assign latched_btn = dir_up ? btn_up : btn_down;
    assign other_btn   = dir_up ? btn_down : btn_up;
    assign timer_enable = (state == HOLD) || (state == REPEAT);
    assign busy        = (state != IDLE);

    temporizador_repeticion #(
        .TERM_A (HOLD_CYCLES),
        .TERM_B (REPEAT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .sel    (state == REPEAT),
        .done   (timer_done)
    );

    always_comb begin
        state_next  = state;
        dir_up_next = dir_up;
        step        = 1'b0;
        step_up     = dir_up;
        case (state)
            IDLE: begin
                if (both_btn) begin
                    state_next = WAIT_REL;
                end else if (en && any_btn) begin
                    step        = 1'b1;
                    step_up     = btn_up;
                    dir_up_next = btn_up;
                    state_next  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (other_btn) begin
                    state_next = WAIT_REL;
                end else if (!latched_btn) begin
                    state_next = IDLE;
                end else if (timer_done) begin
                    step       = 1'b1;
                    state_next = REPEAT;
                end
            end
            WAIT_REL: begin
                if (!any_btn) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // a held button must be released before disable/load can lead to a new step
        if (!en || load) begin
            step       = 1'b0;
            state_next = any_btn ? WAIT_REL : IDLE;
        end
        timer_clear = step || !((state_next == HOLD) || (state_next == REPEAT));
    end

    always_comb begin
        stepped = value;
        if (step_up) begin
            stepped = (value >= max) ? 7'd0 : value + 7'd1;
        end else begin
            stepped = ((value == 7'd0) || (value > max)) ? max : value - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dir_up       <= 1'b1;
            value        <= 7'd0;
            write_strobe <= 1'b0;
        end else begin
            state        <= state_next;
            dir_up       <= dir_up_next;
            write_strobe <= step;
            if (load) begin
                value <= value_in;
            end else if (step) begin
                value <= stepped;
            end
        end
    end

endmodule
